// File: rtl/wb_master_bfm.sv
// Wishbone classic single-transfer initiator: one command in over valid/ready, one Wishbone
// cycle out, one response back. Optional bus timeout via macro WB_MASTER_BFM_TIMEOUT_EN.
module wb_master_bfm #(
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       rstn,
   // command port
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [WB_ADDR_WIDTH-1:0]   req_adr,
   input  logic [WB_DATA_WIDTH-1:0]   req_dat,
   input  logic [WB_DATA_WIDTH/8-1:0] req_sel,
   // response port
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
   output logic                       rsp_err,
   // Wishbone initiator side
   output logic                       wb_cyc_o,
   output logic                       wb_stb_o,
   output logic                       wb_we_o,
   output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
   output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                       wb_ack_i,
   input  logic                       wb_err_i
);

   localparam int SEL_W = WB_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RSP  = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic                       cyc_q, cyc_d;
   logic                       we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
   logic [SEL_W-1:0]           sel_q, sel_d;
   logic [WB_DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
   logic                       rsp_err_q, rsp_err_d;
   logic                       timeout_hit;

`ifdef WB_MASTER_BFM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of BUS cycles already spent without a termination
   assign timeout_hit = (state_q == S_BUS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
      end else if ((state_q == S_BUS) && !wb_ack_i && !wb_err_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // No timeout: BUS waits for ack/err forever; TIMEOUT_CYCLES only keeps the interface uniform.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               we_d    = req_we;
               adr_d   = req_adr;
               dat_d   = req_dat;
               sel_d   = req_sel;
            end
         end
         S_BUS: begin
            // err beats ack, and a real termination beats the timeout
            if (wb_err_i) begin
               state_d   = S_RSP;
               cyc_d     = 1'b0;
               rsp_err_d = 1'b1;
               rsp_dat_d = '0;
            end else if (wb_ack_i) begin
               state_d   = S_RSP;
               cyc_d     = 1'b0;
               rsp_err_d = 1'b0;
               rsp_dat_d = we_q ? '0 : wb_dat_i;
            end else if (timeout_hit) begin
               state_d   = S_RSP;
               cyc_d     = 1'b0;
               rsp_err_d = 1'b1;
               rsp_dat_d = '0;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               state_d   = S_IDLE;
               rsp_err_d = 1'b0;
               rsp_dat_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the command/response registers are reset too, so every output reads 0 during reset.
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE) && rstn;
   assign rsp_valid = (state_q == S_RSP);
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;

   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_wb_master_bfm.sv
// Directed self-checking bench for wb_master_bfm; covers the timeout build when
// WB_MASTER_BFM_TIMEOUT_EN is defined, and the wait-forever build otherwise.
module tb_wb_master_bfm;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_adr;
   logic [DW-1:0] req_dat;
   logic [SW-1:0] req_sel;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_dat;
   logic          rsp_err;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;

   int checks = 0;
   int errors = 0;

   wb_master_bfm #(
      .WB_ADDR_WIDTH (AW),
      .WB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_adr  (req_adr),
      .req_dat  (req_dat),
      .req_sel  (req_sel),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_dat  (rsp_dat),
      .rsp_err  (rsp_err),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // one clock edge, then settle 1 time unit so samples and drives sit away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic [DW-1:0] dat, input logic err);
      check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".rsp_dat"},   64'(rsp_dat),   64'(dat));
      check({tag, ".rsp_err"},   64'(rsp_err),   64'(err));
      check({tag, ".cyc"},       64'(wb_cyc_o),  64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stayed_high;

      rstn      = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_adr   = '0;
      req_dat   = '0;
      req_sel   = '0;
      rsp_ready = 1'b0;
      wb_dat_i  = '0;
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;

      // ---- reset state
      #12;
      check("rst.req_ready", 64'(req_ready), 64'd0);
      check("rst.cyc",       64'(wb_cyc_o),  64'd0);
      check("rst.stb",       64'(wb_stb_o),  64'd0);
      check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst.adr",       64'(wb_adr_o),  64'd0);
      rstn = 1'b1;
      #1;
      check("rst.req_ready_rel", 64'(req_ready), 64'd1);
      tick();

      // ---- write 0x100 <- DEADBEEF, zero-wait ack
      req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h100; req_dat = 32'hDEADBEEF; req_sel = 4'hF;
      tick();
      req_valid = 1'b0;
      check("wr.cyc",       64'(wb_cyc_o),  64'd1);
      check("wr.stb",       64'(wb_stb_o),  64'd1);
      check("wr.we",        64'(wb_we_o),   64'd1);
      check("wr.adr",       64'(wb_adr_o),  64'h100);
      check("wr.dat",       64'(wb_dat_o),  64'hDEADBEEF);
      check("wr.sel",       64'(wb_sel_o),  64'hF);
      check("wr.req_ready", 64'(req_ready), 64'd0);
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      check_rsp("wr", 32'h0, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("wr.rsp_valid_done", 64'(rsp_valid), 64'd0);
      check("wr.req_ready_done", 64'(req_ready), 64'd1);

      // ---- read 0x204 with 3 wait states
      req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h204; req_dat = 32'h0; req_sel = 4'hF;
      tick();
      req_valid = 1'b0; req_adr = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         check("rd.wait_cyc", 64'(wb_cyc_o),  64'd1);
         check("rd.wait_adr", 64'(wb_adr_o),  64'h204);
         check("rd.wait_we",  64'(wb_we_o),   64'd0);
         check("rd.wait_rsp", 64'(rsp_valid), 64'd0);
         tick();
      end
      check("rd.last_cyc", 64'(wb_cyc_o), 64'd1);
      wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
      tick();
      wb_ack_i = 1'b0;
      check_rsp("rd", 32'h12345678, 1'b0);

      // ---- backpressure: stray ack and a pending command while the response is held
      req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h300; req_sel = 4'hF;
      wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp.rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp.rsp_dat",   64'(rsp_dat),   64'h12345678);
         check("bp.rsp_err",   64'(rsp_err),   64'd0);
         check("bp.req_ready", 64'(req_ready), 64'd0);
         check("bp.cyc",       64'(wb_cyc_o),  64'd0);
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp.req_ready_rel", 64'(req_ready), 64'd1);
      check("bp.rsp_valid_rel", 64'(rsp_valid), 64'd0);

      // ---- pending read 0x300 accepted now; ack and err together -> err wins
      tick();
      req_valid = 1'b0;
      check("ae.cyc", 64'(wb_cyc_o), 64'd1);
      check("ae.adr", 64'(wb_adr_o), 64'h300);
      wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hAAAA5555;
      tick();
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      check_rsp("ae", 32'h0, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ---- reset pulsed during BUS
      req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h400; req_sel = 4'hF;
      tick();
      req_valid = 1'b0;
      check("mr.cyc_before", 64'(wb_cyc_o), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("mr.cyc",       64'(wb_cyc_o),  64'd0);
      check("mr.stb",       64'(wb_stb_o),  64'd0);
      check("mr.rsp_valid", 64'(rsp_valid), 64'd0);
      check("mr.req_ready", 64'(req_ready), 64'd0);
      wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A5A5A;
      tick();
      wb_ack_i = 1'b0;
      check("mr.rsp_after_ack", 64'(rsp_valid), 64'd0);
      rstn = 1'b1;
      #1;
      check("mr.req_ready_rel", 64'(req_ready), 64'd1);
      tick();

      // ---- normal write after reset recovery, partial byte selects
      req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h500; req_dat = 32'h0BADF00D; req_sel = 4'h3;
      tick();
      req_valid = 1'b0;
      check("rw.cyc", 64'(wb_cyc_o), 64'd1);
      check("rw.adr", 64'(wb_adr_o), 64'h500);
      check("rw.dat", 64'(wb_dat_o), 64'h0BADF00D);
      check("rw.sel", 64'(wb_sel_o), 64'h3);
      wb_ack_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
      tick();
      wb_ack_i = 1'b0;
      check_rsp("rw", 32'h0, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ---- silent slave
      req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h600; req_sel = 4'hF;
      tick();
      req_valid = 1'b0;
`ifdef WB_MASTER_BFM_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         check("to.cyc_held", 64'(wb_cyc_o), 64'd1);
         tick();
      end
      check_rsp("to", 32'h0, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("to.req_ready", 64'(req_ready), 64'd1);
`else
      stayed_high = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if (wb_cyc_o !== 1'b1 || rsp_valid !== 1'b0) stayed_high = 1'b0;
         tick();
      end
      check("nto.cyc_held_120", 64'(stayed_high), 64'd1);
      check("nto.cyc_now",      64'(wb_cyc_o),    64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("nto.cyc_rst", 64'(wb_cyc_o), 64'd0);
      rstn = 1'b1;
      tick();
      check("nto.req_ready", 64'(req_ready), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
